mips_datapath: RTL and testbench

Multicycle MIPS datapath that sits directly downstream of `control_unit`. Each cycle it consumes that unit's control strobes and selects, and returns `opcode`/`funct` from its instruction register. It holds PC, IR, MDR, A, B, ALUOut, the 32x32 register file and the ALU, and drives a single unified asynchronous-read memory port.

---
 rtl/mips_pkg.sv | 68 ++++++
 rtl/mips_datapath_regfile.sv | 31 +++
 rtl/mips_datapath.sv | 143 ++++++++++++++
 tb/tb_mips_datapath.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath and its control unit:
// ALU operation codes, mux select encodings and instruction field constants.
package mips_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_FUNCT = 4'b1111;

   typedef enum logic [1:0] {
      SRCB_REG     = 2'b00,
      SRCB_FOUR    = 2'b01,
      SRCB_IMM     = 2'b10,
      SRCB_IMM_SH2 = 2'b11
   } srcBSelT;

   typedef enum logic [1:0] {
      DST_RT     = 2'b00,
      DST_RD     = 2'b01,
      DST_RA     = 2'b10,
      DST_RT_ALT = 2'b11
   } regDstSelT;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_BRANCH = 2'b01,
      PCSRC_JUMP   = 2'b10,
      PCSRC_ALUOUT = 2'b11
   } pcSrcSelT;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // Function-field requests decode funct only for R-type; everything else adds.
   function automatic logic [3:0] resolveAluOp(input logic [3:0] aluControl,
                                                input logic [5:0] opcode,
                                                input logic [5:0] funct);
      logic [3:0] op;
      op = aluControl;
      if (aluControl == ALU_FUNCT) begin
         op = ALU_ADD;
         if (opcode == OP_RTYPE) begin
            case (funct)
               FN_SUB:  op = ALU_SUB;
               FN_AND:  op = ALU_AND;
               FN_OR:   op = ALU_OR;
               FN_SLT:  op = ALU_SLT;
               default: op = ALU_ADD;
            endcase
         end
      end
      return op;
   endfunction

endpackage

// File: rtl/mips_datapath_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, asynchronous clear, register 0 hardwired to zero.
module regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rdAddrA,
   input  logic [4:0]  rdAddrB,
   output logic [31:0] rdDataA,
   output logic [31:0] rdDataB,
   input  logic        wrEn,
   input  logic [4:0]  wrAddr,
   input  logic [31:0] wrData
);

   logic [31:0] regsQ [0:31];

   // Writes to register 0 are dropped so it can never hold a stale value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regsQ[i] <= '0;
         end
      end else if (wrEn && (wrAddr != 5'd0)) begin
         regsQ[wrAddr] <= wrData;
      end
   end

   assign rdDataA = (rdAddrA == 5'd0) ? 32'd0 : regsQ[rdAddrA];
   assign rdDataB = (rdAddrB == 5'd0) ? 32'd0 : regsQ[rdAddrB];

endmodule

// File: rtl/mips_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, register file and ALU,
// steered cycle by cycle by control_unit through one unified memory port.
module mips_datapath
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        IorD,
   input  logic        MemWrite,
   input  logic        IRWrite,
   input  logic        MemtoReg,
   input  logic        RegWrite,
   input  logic        ALUSrcA,
   input  logic        Branch,
   input  logic        PCWrite,
   input  logic [1:0]  ALUSrcB,
   input  logic [1:0]  RegDst,
   input  logic [1:0]  PCSrc,
   input  logic [3:0]  ALUControl,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic        zero,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   logic [31:0] pcQ, irQ, mdrQ, aQ, bQ, aluOutQ;
   logic [31:0] pcD;
   logic [31:0] rfRdA, rfRdB, rfWrData;
   logic [4:0]  rfWrAddr;
   logic [31:0] immExt, srcA, srcB, aluResult;
   logic [31:0] branchTarget, jumpTarget;
   logic [3:0]  aluOp;
   logic        pcLoad;

   srcBSelT   srcBSel;
   regDstSelT regDstSel;
   pcSrcSelT  pcSrcSel;

   assign srcBSel   = srcBSelT'(ALUSrcB);
   assign regDstSel = regDstSelT'(RegDst);
   assign pcSrcSel  = pcSrcSelT'(PCSrc);

   assign opcode    = irQ[31:26];
   assign funct     = irQ[5:0];
   assign mem_addr  = IorD ? aluOutQ : pcQ;
   assign mem_wdata = bQ;
   assign mem_we    = MemWrite;

   assign immExt       = {{16{irQ[15]}}, irQ[15:0]};
   assign branchTarget = pcQ + (immExt << 2);
   assign jumpTarget   = {pcQ[31:28], irQ[25:0], 2'b00};
   assign srcA         = ALUSrcA ? aQ : pcQ;

   // ALU operand B selection.
   always_comb begin
      srcB = bQ;
      case (srcBSel)
         SRCB_REG:     srcB = bQ;
         SRCB_FOUR:    srcB = 32'd4;
         SRCB_IMM:     srcB = immExt;
         SRCB_IMM_SH2: srcB = immExt << 2;
      endcase
   end

   // ALU: wrap-around arithmetic, signed slt, unknown codes fall back to add.
   always_comb begin
      aluOp     = resolveAluOp(ALUControl, irQ[31:26], irQ[5:0]);
      aluResult = srcA + srcB;
      case (aluOp)
         ALU_AND: aluResult = srcA & srcB;
         ALU_OR:  aluResult = srcA | srcB;
         ALU_SUB: aluResult = srcA - srcB;
         ALU_SLT: aluResult = ($signed(srcA) < $signed(srcB)) ? 32'd1 : 32'd0;
         default: aluResult = srcA + srcB;
      endcase
   end

   assign zero = (aluResult == 32'd0);

   // Next-PC source and load enable.
   always_comb begin
      pcD = aluResult;
      case (pcSrcSel)
         PCSRC_ALU:    pcD = aluResult;
         PCSRC_BRANCH: pcD = branchTarget;
         PCSRC_JUMP:   pcD = jumpTarget;
         PCSRC_ALUOUT: pcD = aluOutQ;
      endcase
      pcLoad = PCWrite | (Branch & zero);
   end

   // Write-back steering; the link register path always stores the current PC.
   always_comb begin
      rfWrAddr = irQ[20:16];
      rfWrData = MemtoReg ? mdrQ : aluOutQ;
      case (regDstSel)
         DST_RT:     rfWrAddr = irQ[20:16];
         DST_RD:     rfWrAddr = irQ[15:11];
         DST_RA: begin
            rfWrAddr = 5'd31;
            rfWrData = pcQ;
         end
         DST_RT_ALT: rfWrAddr = irQ[20:16];
      endcase
   end

   regfile u_regfile (
      .clk     (clk),
      .reset   (reset),
      .rdAddrA (irQ[25:21]),
      .rdAddrB (irQ[20:16]),
      .rdDataA (rfRdA),
      .rdDataB (rfRdB),
      .wrEn    (RegWrite),
      .wrAddr  (rfWrAddr),
      .wrData  (rfWrData)
   );

   // Architectural and inter-cycle registers; only IR and PC are gated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcQ     <= RESET_PC;
         irQ     <= '0;
         mdrQ    <= '0;
         aQ      <= '0;
         bQ      <= '0;
         aluOutQ <= '0;
      end else begin
         if (IRWrite) irQ <= mem_rdata;
         if (pcLoad)  pcQ <= pcD;
         mdrQ    <= mem_rdata;
         aQ      <= rfRdA;
         bQ      <= rfRdB;
         aluOutQ <= aluResult;
      end
   end

endmodule

// File: tb/tb_mips_datapath.sv
// Drives the datapath through instruction-level control sequences and checks
// it against an architectural model of the register file, PC and memory.
module tb_mips_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic        IorD, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite;
   logic [1:0]  ALUSrcB, RegDst, PCSrc;
   logic [3:0]  ALUControl;
   logic [5:0]  opcode, funct;
   logic        zero, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:255];
   logic [31:0] regsM [0:31];
   logic [31:0] pcM;
   int          total = 0;
   int          bad = 0;

   assign mem_rdata = mem[mem_addr[9:2]];

   mips_datapath #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .IorD       (IorD),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .Branch     (Branch),
      .PCWrite    (PCWrite),
      .ALUSrcB    (ALUSrcB),
      .RegDst     (RegDst),
      .PCSrc      (PCSrc),
      .ALUControl (ALUControl),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running required=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   // Architectural meaning of each R-type function code.
   function automatic logic [31:0] aluRef(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         6'b100010: return a - b;
         6'b100100: return a & b;
         6'b100101: return a | b;
         6'b101010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default:   return a + b;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic idleControls();
      IorD = 0; MemWrite = 0; IRWrite = 0; MemtoReg = 0; RegWrite = 0;
      ALUSrcA = 0; Branch = 0; PCWrite = 0;
      ALUSrcB = 2'b00; RegDst = 2'b00; PCSrc = 2'b00; ALUControl = 4'b0010;
   endtask

   // One rising edge with the current controls; memory commits a store at that edge.
   task automatic applyStimulus();
      logic        doWrite;
      logic [31:0] wAddr, wData;
      #1;
      doWrite = mem_we;
      wAddr   = mem_addr;
      wData   = mem_wdata;
      @(posedge clk);
      if (doWrite) mem[wAddr[9:2]] = wData;
      #1;
      idleControls();
   endtask

   task automatic modelReset();
      for (int i = 0; i < 32; i++) regsM[i] = 32'd0;
      pcM = 32'd0;
   endtask

   task automatic fetchInstr(input logic [31:0] instr);
      mem[pcM[9:2]] = instr;
      IorD = 0; IRWrite = 1; ALUSrcA = 0; ALUSrcB = 2'b01;
      ALUControl = 4'b0010; PCSrc = 2'b00; PCWrite = 1;
      applyStimulus();
      pcM = pcM + 32'd4;
   endtask

   task automatic decodeStep();
      ALUSrcA = 0; ALUSrcB = 2'b11; ALUControl = 4'b0010;
      applyStimulus();
   endtask

   task automatic writeModel(input logic [4:0] r, input logic [31:0] v);
      if (r != 5'd0) regsM[r] = v;
   endtask

   // B is observed on mem_wdata, A via ALUOut = A + 0 on mem_addr.
   task automatic readReg(input logic [4:0] r);
      fetchInstr({6'd0, r, r, 16'd0});
      decodeStep();
      checkOutput($sformatf("regB%0d", r), mem_wdata, regsM[r]);
      ALUSrcA = 1; ALUSrcB = 2'b10; ALUControl = 4'b0010;
      applyStimulus();
      IorD = 1;
      #1;
      checkOutput($sformatf("regA%0d", r), mem_addr, regsM[r]);
      IorD = 0;
   endtask

   task automatic loadWord(input logic [4:0] r, input logic [31:0] value);
      mem[240] = value;
      fetchInstr({6'b100011, 5'd0, r, 16'h03C0});
      decodeStep();
      ALUSrcA = 1; ALUSrcB = 2'b10; ALUControl = 4'b0010;
      applyStimulus();
      IorD = 1;
      applyStimulus();
      RegDst = 2'b00; MemtoReg = 1; RegWrite = 1;
      applyStimulus();
      writeModel(r, value);
   endtask

   task automatic addiExec(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
      logic [31:0] expected;
      expected = regsM[rs] + {{16{imm[15]}}, imm};
      decodeStep();
      ALUSrcA = 1; ALUSrcB = 2'b10; ALUControl = 4'b1111;
      applyStimulus();
      RegDst = 2'b00; MemtoReg = 0; RegWrite = 1; IorD = 1;
      #1;
      checkOutput("addiAluOut", mem_addr, expected);
      applyStimulus();
      writeModel(rt, expected);
   endtask

   task automatic addiOp(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
      fetchInstr({6'b001000, rs, rt, imm});
      addiExec(rt, rs, imm);
   endtask

   task automatic rtypeOp(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] f);
      logic [31:0] expected;
      expected = aluRef(f, regsM[rs], regsM[rt]);
      fetchInstr({6'd0, rs, rt, rd, 5'd0, f});
      decodeStep();
      ALUSrcA = 1; ALUSrcB = 2'b00; ALUControl = 4'b1111;
      applyStimulus();
      RegDst = 2'b01; MemtoReg = 0; RegWrite = 1; IorD = 1;
      #1;
      checkOutput($sformatf("rtype_f%02h", f), mem_addr, expected);
      applyStimulus();
      writeModel(rd, expected);
   endtask

   task automatic jumpTo(input logic [31:0] target);
      fetchInstr({6'b000010, target[27:2]});
      PCSrc = 2'b10; PCWrite = 1;
      applyStimulus();
      pcM = {pcM[31:28], target[27:2], 2'b00};
   endtask

   task automatic beqOp(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
      logic taken;
      taken = (regsM[rs] == regsM[rt]);
      fetchInstr({6'b000100, rs, rt, imm});
      decodeStep();
      ALUSrcA = 1; ALUSrcB = 2'b00; ALUControl = 4'b0110; Branch = 1; PCSrc = 2'b01;
      #1;
      checkOutput("beqZero", {31'd0, zero}, {31'd0, taken});
      applyStimulus();
      if (taken) pcM = pcM + ({{16{imm[15]}}, imm} << 2);
      checkOutput("beqPc", mem_addr, pcM);
   endtask

   logic [5:0]  functList [0:5];
   logic [4:0]  rs, rt, rd;
   logic [31:0] va, vb;

   initial begin
      functList[0] = 6'b100000; functList[1] = 6'b100010; functList[2] = 6'b100100;
      functList[3] = 6'b100101; functList[4] = 6'b101010; functList[5] = 6'b000111;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      idleControls();
      modelReset();
      reset = 1;
      #12;
      reset = 0;
      @(posedge clk);
      #1;
      checkOutput("initMemAddr", mem_addr, 32'd0);
      checkOutput("initOpcode", {26'd0, opcode}, 32'd0);

      // Dirty some state, then reset in the middle of an instruction.
      va = $urandom | 32'd1;
      loadWord(5'd5, va);
      readReg(5'd5);
      addiOp(5'd5, 5'd5, 16'h0001);
      #3;
      reset = 1;
      MemWrite = 1;
      #1;
      checkOutput("rstMemAddr", mem_addr, 32'd0);
      checkOutput("rstOpcode", {26'd0, opcode}, 32'd0);
      checkOutput("rstFunct", {26'd0, funct}, 32'd0);
      checkOutput("rstWdata", mem_wdata, 32'd0);
      checkOutput("rstMemWe", {31'd0, mem_we}, 32'd1);
      MemWrite = 0;
      #2;
      reset = 0;
      modelReset();
      @(posedge clk);
      #1;

      fetchInstr(32'h2008_0005);
      checkOutput("fetchOpcode", {26'd0, opcode}, 32'h0000_0008);
      checkOutput("fetchFunct", {26'd0, funct}, 32'h0000_0005);
      checkOutput("fetchPc", mem_addr, 32'h0000_0004);
      addiExec(5'd8, 5'd0, 16'h0005);
      readReg(5'd8);
      readReg(5'd5);

      addiOp(5'd9, 5'd0, 16'h0007);
      rtypeOp(5'd8, 5'd9, 5'd10, 6'b100010);
      readReg(5'd10);
      rtypeOp(5'd8, 5'd9, 5'd11, 6'b101010);
      readReg(5'd11);

      addiOp(5'd12, 5'd0, 16'h0003);
      addiOp(5'd13, 5'd0, 16'h0003);
      addiOp(5'd14, 5'd0, 16'h0004);
      jumpTo(32'h0000_0004);
      beqOp(5'd12, 5'd13, 16'hFFFE);
      jumpTo(32'h0000_0004);
      beqOp(5'd12, 5'd14, 16'hFFFE);

      jumpTo(32'h0000_000C);
      fetchInstr({6'b000011, 26'h40});
      RegDst = 2'b10; RegWrite = 1; PCSrc = 2'b10; PCWrite = 1;
      applyStimulus();
      writeModel(5'd31, pcM);
      pcM = {pcM[31:28], 26'h40, 2'b00};
      checkOutput("jalPc", mem_addr, pcM);
      readReg(5'd31);
      addiOp(5'd0, 5'd0, 16'h1234);
      readReg(5'd0);

      // Store rf[10] to word 250 through the memory port.
      fetchInstr({6'b101011, 5'd0, 5'd10, 16'h03E8});
      decodeStep();
      ALUSrcA = 1; ALUSrcB = 2'b10; ALUControl = 4'b0010;
      applyStimulus();
      IorD = 1; MemWrite = 1;
      #1;
      checkOutput("swWe", {31'd0, mem_we}, 32'd1);
      checkOutput("swAddr", mem_addr, 32'h0000_03E8);
      applyStimulus();
      checkOutput("swMem", mem[250], regsM[10]);

      for (int n = 0; n < 10; n++) begin
         rs = 5'($urandom_range(1, 31));
         rt = 5'($urandom_range(1, 31));
         rd = 5'($urandom_range(0, 31));
         va = $urandom;
         vb = ($urandom_range(0, 3) == 0) ? va : $urandom;
         loadWord(rs, va);
         loadWord(rt, vb);
         rtypeOp(rs, rt, rd, functList[$urandom_range(0, 5)]);
         readReg(rd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
